stall_control: RTL
==================

STALL_CONTROL -- requirements
Module: stall_control

Interface
REQ-001 Parameter MEM_TIMEOUT, default 15: maximum consecutive data-memory wait cycles before a timeout is flagged.
REQ-002 Parameter CNT_W, default 16: width of the stall performance counter.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-low; 0 = reset asserted.
REQ-005 RS1D, RS2D  input  5 each  source registers of the instruction in Decode.
REQ-006 RDE  input  5  destination register of the instruction in Execute.
REQ-007 MemReadE  input  1  the Execute instruction is a load.
REQ-008 PCSrcE  input  1  branch or jump taken, resolved in Execute.
REQ-009 MemReqM  input  1  the Memory-stage instruction accesses data memory.
REQ-010 MemReadyM  input  1  data memory completes the access this cycle.
REQ-011 StallF, StallD, StallE, StallM  output  1 each  hold the PC and the pipeline registers of the named stage.
REQ-012 FlushD, FlushE, FlushW  output  1 each  insert a bubble into the D, E or W pipeline register.
REQ-013 MemTimeout  output  1  sticky error flag: a memory wait exceeded MEM_TIMEOUT.
REQ-014 StallCount  output  CNT_W  saturating count of cycles in which StallF = 1.

Function
REQ-015 The FSM SHALL have states IDLE, MEM_WAIT and TIMEOUT, with a wait counter of width clog2(MEM_TIMEOUT+1).
REQ-016 The memory-wait condition SHALL be MemReqM=1 and MemReadyM=0.
REQ-017 In IDLE or MEM_WAIT with the memory-wait condition true, the block SHALL assert StallF, StallD, StallE, StallM and FlushW in that same cycle (combinational) and deassert all other outputs.
REQ-018 IDLE -> MEM_WAIT SHALL occur on the memory-wait condition, with the wait counter loaded to 1.
REQ-019 In MEM_WAIT, MemReadyM=1 SHALL deassert all stalls in that cycle and return the FSM to IDLE, with the counter cleared.
REQ-020 In MEM_WAIT, the counter SHALL increment each cycle the wait persists; when the counter equals MEM_TIMEOUT and the wait persists, the FSM SHALL enter TIMEOUT.
REQ-021 TIMEOUT SHALL hold all four stalls and FlushW, assert MemTimeout, ignore every input, and be left only by reset.
REQ-022 A load-use hazard SHALL be MemReadE=1, RDE!=0, and RDE==RS1D or RDE==RS2D.
REQ-023 A load-use hazard in IDLE with no memory wait SHALL assert StallF, StallD and FlushE for exactly that cycle, with no state change.
REQ-024 PCSrcE=1 in IDLE with no memory wait SHALL assert FlushD and FlushE; load-use stall SHALL be suppressed in that cycle.
REQ-025 Priority SHALL be: TIMEOUT > memory wait > branch flush > load-use.
REQ-026 PCSrcE and the load-use hazard SHALL be ignored while a memory stall is active; they are re-evaluated after release because E is frozen.
REQ-027 StallCount SHALL increment on each clock edge where StallF=1 and hold at all-ones (no wrap).
REQ-028 Register 0 SHALL never cause a load-use stall.

Reset
REQ-029 With reset=0, the FSM SHALL be IDLE, the wait counter 0, StallCount 0 and MemTimeout 0, asynchronously.
REQ-030 With reset=0, every stall and flush output SHALL be 0 regardless of the other inputs.
REQ-031 Reset asserted during MEM_WAIT or TIMEOUT SHALL return the block to IDLE immediately; the first post-reset edge SHALL evaluate inputs from IDLE.

Structure
REQ-032 A shared package hazard_pkg SHALL hold the FSM state enum (IDLE, MEM_WAIT, TIMEOUT), the MEM_TIMEOUT default and the register-index width 5.
REQ-033 The wait counter and compare SHALL be a sub-module wait_timer (load, increment, clear, expired output).
REQ-034 The load-use and branch decode SHALL remain combinational in stall_control; state SHALL live only in the FSM, wait_timer and StallCount.

Verification
REQ-035 Load-use: MemReadE=1, RDE=5, RS2D=5, memory idle -> StallF=StallD=FlushE=1 for one cycle, then StallCount=1.
REQ-036 Register 0: MemReadE=1, RDE=0, RS1D=0 -> all outputs 0.
REQ-037 Branch plus load-use in the same cycle: PCSrcE=1 and the hazard true -> FlushD=FlushE=1, StallF=0.
REQ-038 Memory wait: MemReqM=1, MemReadyM=0 for 3 cycles, then MemReadyM=1 -> all four stalls and FlushW high for 3 cycles, low on the 4th, FSM back in IDLE, StallCount=3.
REQ-039 Timeout: with MEM_TIMEOUT=15, MemReadyM held 0 for 17 cycles -> MemTimeout=1 from the TIMEOUT entry and stays 1 after MemReadyM=1.
REQ-040 Reset mid-wait, plus saturation: reset pulsed low during MEM_WAIT -> outputs 0 at once and state IDLE. With CNT_W=4 and 20 stall cycles -> StallCount=15.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard/stall control slice:
// FSM states, the register-index width and the default memory-wait limit.
package hazard_pkg;

   localparam int REG_W               = 5;
   localparam int MEM_TIMEOUT_DEFAULT = 15;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      MEM_WAIT = 2'd1,
      TIMEOUT  = 2'd2
   } state_e;

   // x0 is hard-wired to zero, so it can never carry a pending load result.
   function automatic logic reg_depends(input logic [REG_W-1:0] rd,
                                        input logic [REG_W-1:0] rs);
      return (rd != {REG_W{1'b0}}) && (rd == rs);
   endfunction

endpackage

// File: rtl/wait_timer.sv
// Counts consecutive data-memory wait cycles; expired flags that the count
// has reached LIMIT so the controller can escalate to a timeout.
module wait_timer
   import hazard_pkg::*;
#(
   parameter int LIMIT = MEM_TIMEOUT_DEFAULT,
   parameter int WIDTH = $clog2(LIMIT + 1)
) (
   input  logic clk,
   input  logic reset,
   input  logic load,
   input  logic inc,
   input  logic clr,
   output logic expired
);

   logic [WIDTH-1:0] count_r;

   assign expired = (count_r == WIDTH'(LIMIT));

   // Wait counter: clear wins over load, load over increment; never passes LIMIT.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count_r <= {WIDTH{1'b0}};
      end else if (clr) begin
         count_r <= {WIDTH{1'b0}};
      end else if (load) begin
         count_r <= WIDTH'(1);
      end else if (inc && !expired) begin
         count_r <= count_r + WIDTH'(1);
      end else begin
         count_r <= count_r;
      end
   end

endmodule

// File: rtl/stall_control.sv
// Pipeline stall/flush controller: data-memory wait FSM with timeout,
// branch flush and load-use interlock, plus a saturating stall counter.
module stall_control
   import hazard_pkg::*;
#(
   parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEFAULT,
   parameter int CNT_W       = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [REG_W-1:0] RS1D,
   input  logic [REG_W-1:0] RS2D,
   input  logic [REG_W-1:0] RDE,
   input  logic             MemReadE,
   input  logic             PCSrcE,
   input  logic             MemReqM,
   input  logic             MemReadyM,
   output logic             StallF,
   output logic             StallD,
   output logic             StallE,
   output logic             StallM,
   output logic             FlushD,
   output logic             FlushE,
   output logic             FlushW,
   output logic             MemTimeout,
   output logic [CNT_W-1:0] StallCount
);

   state_e           state_r;
   state_e           state_s;
   logic             mem_wait_s;
   logic             load_use_s;
   logic             timer_load_s;
   logic             timer_inc_s;
   logic             timer_clr_s;
   logic             timer_expired_s;
   logic [CNT_W-1:0] stall_count_r;

   assign mem_wait_s = MemReqM && !MemReadyM;
   assign load_use_s = MemReadE && (reg_depends(RDE, RS1D) || reg_depends(RDE, RS2D));
   assign StallCount = stall_count_r;

   wait_timer #(
      .LIMIT (MEM_TIMEOUT)
   ) u_wait_timer (
      .clk     (clk),
      .reset   (reset),
      .load    (timer_load_s),
      .inc     (timer_inc_s),
      .clr     (timer_clr_s),
      .expired (timer_expired_s)
   );

   // FSM state register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Next state and stall/flush decode; outputs are forced low while reset is held.
   always_comb begin
      state_s      = state_r;
      timer_load_s = 1'b0;
      timer_inc_s  = 1'b0;
      timer_clr_s  = 1'b0;
      StallF       = 1'b0;
      StallD       = 1'b0;
      StallE       = 1'b0;
      StallM       = 1'b0;
      FlushD       = 1'b0;
      FlushE       = 1'b0;
      FlushW       = 1'b0;
      MemTimeout   = 1'b0;
      if (!reset) begin
         state_s = IDLE;
      end else begin
         case (state_r)
            IDLE: begin
               if (mem_wait_s) begin
                  {StallF, StallD, StallE, StallM, FlushW} = 5'b11111;
                  timer_load_s = 1'b1;
                  state_s      = MEM_WAIT;
               end else if (PCSrcE) begin
                  FlushD = 1'b1;
                  FlushE = 1'b1;
               end else if (load_use_s) begin
                  StallF = 1'b1;
                  StallD = 1'b1;
                  FlushE = 1'b1;
               end else begin
                  state_s = IDLE;
               end
            end
            MEM_WAIT: begin
               // The release cycle drives nothing: E is frozen, so hazards are
               // picked up again from IDLE on the following cycle.
               if (!mem_wait_s) begin
                  timer_clr_s = 1'b1;
                  state_s     = IDLE;
               end else if (timer_expired_s) begin
                  {StallF, StallD, StallE, StallM, FlushW} = 5'b11111;
                  state_s = TIMEOUT;
               end else begin
                  {StallF, StallD, StallE, StallM, FlushW} = 5'b11111;
                  timer_inc_s = 1'b1;
               end
            end
            TIMEOUT: begin
               {StallF, StallD, StallE, StallM, FlushW} = 5'b11111;
               MemTimeout = 1'b1;
            end
            default: begin
               timer_clr_s = 1'b1;
               state_s     = IDLE;
            end
         endcase
      end
   end

   // Saturating count of fetch-stall cycles.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stall_count_r <= {CNT_W{1'b0}};
      end else if (StallF && (stall_count_r != {CNT_W{1'b1}})) begin
         stall_count_r <= stall_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
         stall_count_r <= stall_count_r;
      end
   end

endmodule
